// File: rtl/mux_sync_src_ctrl.sv
// Source-side controller for a mux-synchronizer crossing: holds a word, raises a request level,
// and completes a four-phase req/ack handshake. Optional ack-wait watchdog: MUX_SYNC_SRC_TIMEOUT_EN.
`timescale 1ns/1ps

module mux_sync_src_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int SYNC_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] xfer_data_o,
    output logic                  xfer_req_o,
    input  logic                  xfer_ack_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  timeout_o,
    output logic [1:0]            dbg_state_o
);

    // Handshake: a word moves on every rising edge where valid_i && ready_o; data_i need only be
    // stable in that cycle, and ready_o never depends on valid_i.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_DEPTH-1:0]   ack_sync_q;
    logic                    ack_s;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    accept;
    logic                    done_raw;
    logic                    timeout_raw;
    logic                    expired;

    // Only this chain samples the asynchronous ack level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_DEPTH-2:0], xfer_ack_i};
        end
    end

    assign ack_s = ack_sync_q[SYNC_DEPTH-1];

`ifdef MUX_SYNC_SRC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    // Counts cycles spent in the current busy state; restarts on every state change.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if ((state_d != state_q) || (state_q == IDLE)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;

    // Watchdog compiled out: the limit parameter has no effect and busy states wait forever.
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign expired            = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= data_i;
            end
        end
    end

    // An ack edge seen in the same cycle as expiry takes the normal path.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        done_raw    = 1'b0;
        timeout_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i && !ack_s) begin
                    accept  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    state_d = REL;
                end else if (expired) begin
                    timeout_raw = 1'b1;
                    state_d     = REL;
                end
            end
            REL: begin
                if (!ack_s) begin
                    done_raw = 1'b1;
                    state_d  = IDLE;
                end else if (expired) begin
                    timeout_raw = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready_o     = (state_q == IDLE) && !ack_s;
    assign xfer_req_o  = (state_q == REQ);
    assign busy_o      = (state_q != IDLE);
    assign xfer_data_o = data_q;
    assign done_o      = done_raw && !rst_i;
    assign timeout_o   = timeout_raw && !rst_i;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mux_sync_src_ctrl.sv
// Bench for mux_sync_src_ctrl: directed scenarios plus a randomized run checked against
// a cycle model built from ack history and per-phase dwell time.
`timescale 1ns/1ps

module tb_mux_sync_src_ctrl;

    localparam int DW = 32;
    localparam int SD = 2;
    localparam int TO = 8;
`ifdef MUX_SYNC_SRC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [DW-1:0] data_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [DW-1:0] xfer_data_o;
    logic          xfer_req_o;
    logic          xfer_ack_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic          timeout_o;
    logic [1:0]    dbg_state_o;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = waiting, 1 = requesting, 2 = releasing.
    int            m_state;
    logic [DW-1:0] m_data;
    int            m_age;
    bit            ackq[$];
    logic [DW-1:0] exp_q[$];
    bit            sb_en = 1'b0;

    // Destination responder.
    bit resp_en = 1'b0;
    bit resp_rand = 1'b0;
    int r_up = 3;
    int r_dn = 3;
    int r_cnt = 0;

    mux_sync_src_ctrl #(
        .DATA_WIDTH    (DW),
        .SYNC_DEPTH    (SD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .xfer_data_o (xfer_data_o),
        .xfer_req_o  (xfer_req_o),
        .xfer_ack_i  (xfer_ack_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .timeout_o   (timeout_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1);
    end

    task automatic model_reset();
        m_state = 0;
        m_data  = '0;
        m_age   = 0;
        ackq.delete();
        for (int i = 0; i < SD; i++) ackq.push_back(1'b0);
        exp_q.delete();
    endtask

    function automatic logic [DW+4:0] exp_vec();
        logic s;
        logic e_to;
        s    = ackq[0];
        e_to = TO_EN && !rst_i && (m_age == TO) && ((m_state == 1 && !s) || (m_state == 2 && s));
        return {(m_state == 0) && !s, m_state == 1, m_state != 0,
                (m_state == 2) && !s && !rst_i, e_to, m_data};
    endfunction

    function automatic logic [DW+4:0] dut_vec();
        return {ready_o, xfer_req_o, busy_o, done_o, timeout_o, xfer_data_o};
    endfunction

    // ---------------- driver ----------------
    task automatic resp_step();
        if (!resp_en) return;
        if (xfer_req_o && !xfer_ack_i) begin
            r_cnt++;
            if (r_cnt >= r_up) begin xfer_ack_i = 1'b1; r_cnt = 0; end
        end else if (!xfer_req_o && xfer_ack_i) begin
            r_cnt++;
            if (r_cnt >= r_dn) begin
                xfer_ack_i = 1'b0;
                r_cnt = 0;
                if (resp_rand) begin
                    r_up = $urandom_range(1, 6);
                    r_dn = $urandom_range(1, 6);
                end
            end
        end else begin
            r_cnt = 0;
        end
    endtask

    // One clock: model advances on the same inputs the DUT sees at the edge.
    task automatic tick();
        bit s;
        int nst;
        bit acc;
        logic [DW-1:0] d;
        bit r;
        bit a;
        s = ackq[0]; nst = m_state; acc = 1'b0;
        d = data_i; r = rst_i; a = xfer_ack_i;
        if (m_state == 0) begin
            if (valid_i && !s) begin acc = 1'b1; nst = 1; end
        end else if (m_state == 1) begin
            if (s || (TO_EN && m_age == TO)) nst = 2;
        end else begin
            if (!s) nst = 0;
            else if (TO_EN && m_age == TO) begin
                nst = 0;
                if (sb_en && exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (acc) begin
                m_data = d;
                if (sb_en) exp_q.push_back(d);
            end
            m_age = (nst != m_state) ? 0 : ((nst != 0) ? m_age + 1 : 0);
            m_state = nst;
            ackq.push_back(a);
            void'(ackq.pop_front());
        end
        #1;
        resp_step();
    endtask

    task automatic do_reset();
        rst_i = 1'b1; valid_i = 1'b0; xfer_ack_i = 1'b0; r_cnt = 0;
        tick(); tick();
        rst_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {DW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), {1'b1, 4'b0, {DW{1'b0}}});
        end
    endtask

    task automatic test_single();
        int done_cnt = 0;
        bit after_done = 1'b0;
        do_reset();
        resp_en = 1'b1; resp_rand = 1'b0; r_up = 3; r_dn = 3;
        valid_i = 1'b1; data_i = 32'hA5A5_0001;
        tick();
        valid_i = 1'b0;
        checks++;
        if ({xfer_req_o, ready_o, xfer_data_o} !== {1'b1, 1'b0, 32'hA5A5_0001}) begin
            errors++;
            $display("FAIL single_accept: got req=%b ready=%b data=%h want req=1 ready=0 data=a5a50001",
                     xfer_req_o, ready_o, xfer_data_o);
        end
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_model cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (after_done) begin
                after_done = 1'b0;
                checks++;
                if ({ready_o, busy_o} !== 2'b10) begin
                    errors++;
                    $display("FAIL single_idle_after_done: got ready=%b busy=%b want ready=1 busy=0",
                             ready_o, busy_o);
                end
            end
            if (done_o) begin done_cnt++; after_done = 1'b1; end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL single_done_count: got %0d want 1", done_cnt);
        end
        resp_en = 1'b0;
    endtask

    task automatic test_hold_valid();
        logic [DW-1:0] first;
        bit seen_done = 1'b0;
        do_reset();
        resp_en = 1'b1; resp_rand = 1'b0; r_up = 2; r_dn = 2;
        first = $urandom;
        valid_i = 1'b1; data_i = first;
        tick();
        for (int i = 0; i < 60 && !seen_done; i++) begin
            data_i = $urandom;
            tick();
            checks++;
            if (xfer_data_o !== first || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL hold_valid cyc %0d: got data=%h vec=%h want data=%h vec=%h",
                         i, xfer_data_o, dut_vec(), first, exp_vec());
            end
            if (done_o) seen_done = 1'b1;
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL hold_valid_done: got no done want done pulse");
        end
        valid_i = 1'b0; resp_en = 1'b0;
    endtask

    task automatic test_stale_ack();
        int n = 0;
        do_reset();
        xfer_ack_i = 1'b1;
        repeat (4) tick();
        valid_i = 1'b1; data_i = 32'hC0DE_0039;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({ready_o, busy_o} !== 2'b00 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stale_ack_block cyc %0d: got ready=%b busy=%b want ready=0 busy=0",
                         i, ready_o, busy_o);
            end
        end
        xfer_ack_i = 1'b0;
        while (!busy_o && n < 10) begin tick(); n++; end
        checks++;
        if (n != SD + 1 || xfer_data_o !== 32'hC0DE_0039 || xfer_req_o !== 1'b1) begin
            errors++;
            $display("FAIL stale_ack_release: got cycles=%0d data=%h req=%b want cycles=%0d data=c0de0039 req=1",
                     n, xfer_data_o, xfer_req_o, SD + 1);
        end
        valid_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        valid_i = 1'b1; data_i = 32'h1234_5678;
        tick();
        valid_i = 1'b0;
        tick(); tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++;
        if ({xfer_req_o, busy_o, done_o, xfer_data_o} !== {3'b000, {DW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_in_req: got req=%b busy=%b done=%b data=%h want all 0",
                     xfer_req_o, busy_o, done_o, xfer_data_o);
        end
        valid_i = 1'b1; data_i = 32'h8765_4321;
        tick();
        valid_i = 1'b0; xfer_ack_i = 1'b1;
        while (!(busy_o && !xfer_req_o) && n < 10) begin tick(); n++; end
        checks++;
        if (n != SD + 1) begin
            errors++;
            $display("FAIL reach_rel: got cycles=%0d want %0d", n, SD + 1);
        end
        xfer_ack_i = 1'b0;
        repeat (SD) tick();
        rst_i = 1'b1;
        #1;
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_rel_done: got done=%b want 0", done_o);
        end
        tick();
        rst_i = 1'b0;
        checks++;
        if ({busy_o, done_o, xfer_data_o} !== {2'b00, {DW{1'b0}}}) begin
            errors++;
            $display("FAIL reset_in_rel: got busy=%b done=%b data=%h want all 0", busy_o, done_o, xfer_data_o);
        end
    endtask

    task automatic test_timeout();
        int k = 1;
        do_reset();
        valid_i = 1'b1; data_i = 32'hDEAD_0008;
        tick();
        valid_i = 1'b0;
        if (TO_EN) begin
            while (!timeout_o && k < 30) begin tick(); k++; end
            checks++;
            if (!timeout_o || k != TO + 1 || !xfer_req_o) begin
                errors++;
                $display("FAIL timeout_req: got to=%b req_cycle=%0d want to=1 req_cycle=%0d", timeout_o, k, TO + 1);
            end
            tick();
            checks++;
            if ({xfer_req_o, busy_o, done_o, timeout_o} !== 4'b0110) begin
                errors++;
                $display("FAIL timeout_rel: got req=%b busy=%b done=%b to=%b want 0110",
                         xfer_req_o, busy_o, done_o, timeout_o);
            end
            tick();
            checks++;
            if ({ready_o, busy_o, done_o} !== 3'b100) begin
                errors++;
                $display("FAIL timeout_idle: got ready=%b busy=%b done=%b want 100", ready_o, busy_o, done_o);
            end
            // Ack arriving on the expiry cycle wins.
            valid_i = 1'b1;
            tick();
            valid_i = 1'b0;
            repeat (TO - SD) tick();
            xfer_ack_i = 1'b1;
            repeat (SD) tick();
            checks++;
            if ({xfer_req_o, timeout_o} !== 2'b10 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL ack_wins_req: got req=%b to=%b want req=1 to=0", xfer_req_o, timeout_o);
            end
            tick();
            checks++;
            if ({xfer_req_o, busy_o, timeout_o, done_o} !== 4'b0100) begin
                errors++;
                $display("FAIL ack_wins_rel: got req=%b busy=%b to=%b done=%b want 0100",
                         xfer_req_o, busy_o, timeout_o, done_o);
            end
        end else begin
            for (int i = 0; i < 40; i++) begin
                tick();
                checks++;
                if ({xfer_req_o, timeout_o} !== 2'b10) begin
                    errors++;
                    $display("FAIL no_timeout cyc %0d: got req=%b to=%b want req=1 to=0", i, xfer_req_o, timeout_o);
                end
            end
        end
        xfer_ack_i = 1'b0;
    endtask

    task automatic test_random();
        logic [DW-1:0] w;
        do_reset();
        sb_en = 1'b1; resp_en = 1'b1; resp_rand = 1'b1;
        r_up = $urandom_range(1, 6); r_dn = $urandom_range(1, 6);
        for (int i = 0; i < 600; i++) begin
            rst_i   = ($urandom_range(0, 149) == 0);
            valid_i = $urandom_range(0, 1);
            data_i  = $urandom;
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_model cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (exp_vec()[DW+1]) begin
                checks++;
                w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                if (xfer_data_o !== w) begin
                    errors++;
                    $display("FAIL random_scoreboard cyc %0d: got %h want %h", i, xfer_data_o, w);
                end
            end
        end
        rst_i = 1'b0; valid_i = 1'b0; sb_en = 1'b0; resp_en = 1'b0;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        model_reset();
        test_reset();
        test_single();
        test_hold_valid();
        test_stale_ack();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_sync_src_ctrl.md
MUX_SYNC_SRC_CTRL -- requirements
Module: mux_sync_src_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the transferred data word.
REQ-002 Parameter SYNC_DEPTH, default 2, number of flops in the internal ack synchronizer, legal value >= 2.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, ack-wait limit in clk_i cycles, legal value >= 1.
REQ-004 clk_i  in  1  the only clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  synchronous reset, active-high.
REQ-006 data_i  in  DATA_WIDTH  word offered for transfer.
REQ-007 valid_i  in  1  data_i valid.
REQ-008 ready_o  out  1  controller can accept a word.
REQ-009 xfer_data_o  out  DATA_WIDTH  held word, drives the destination mux-sync data input.
REQ-010 xfer_req_o  out  1  request level, drives the destination sync_ctrl.
REQ-011 xfer_ack_i  in  1  acknowledge level from the destination domain, asynchronous to clk_i.
REQ-012 busy_o  out  1  transfer in progress.
REQ-013 done_o  out  1  one-cycle pulse, handshake completed.
REQ-014 timeout_o  out  1  one-cycle pulse, ack wait expired.

Function
REQ-015 xfer_ack_i shall pass through a SYNC_DEPTH-flop synchronizer; ack_s is the last stage, and no other logic shall sample xfer_ack_i.
REQ-016 FSM states: IDLE, REQ, REL.
REQ-017 ready_o shall be 1 only in IDLE with ack_s=0; a stale high ack blocks acceptance.
REQ-018 IDLE with valid_i=1 and ready_o=1 means accept: capture data_i into xfer_data_o and enter REQ on the next edge.
REQ-019 xfer_req_o shall be 1 exactly while in REQ; the first cycle xfer_req_o=1 shall already present the captured word.
REQ-020 xfer_data_o shall stay constant from acceptance until the next acceptance, including through IDLE.
REQ-021 REQ with ack_s=1 means go to REL.
REQ-022 REL with ack_s=0 means go to IDLE, with done_o=1 in the cycle of that transition.
REQ-023 busy_o shall be 1 in REQ and REL.
REQ-024 valid_i outside IDLE shall be ignored; no data capture occurs.
REQ-025 Minimum accept-to-accept spacing is 2 + 2*SYNC_DEPTH cycles plus destination latency.

Reset
REQ-026 rst_i=1 at a clock edge shall force IDLE, with xfer_data_o=0, xfer_req_o=0, done_o=0, timeout_o=0, synchronizer flops=0, timeout counter=0.
REQ-027 busy_o shall be 0 and ready_o 1 in the first cycle after reset release.
REQ-028 Reset asserted mid-operation, in REQ or REL, shall abandon the transfer with no done_o pulse.
REQ-029 rst_i shall take priority over every other event in the same cycle.

Configuration
REQ-030 Macro MUX_SYNC_SRC_TIMEOUT_EN, when defined, shall enable a counter of width $clog2(TIMEOUT_CYCLES+1).
REQ-031 The counter shall clear on each state entry and increment each cycle in REQ or REL.
REQ-032 In REQ, reaching TIMEOUT_CYCLES shall pulse timeout_o and go to REL.
REQ-033 In REL, reaching TIMEOUT_CYCLES shall pulse timeout_o and go to IDLE without done_o.
REQ-034 An ack_s transition in the same cycle as the timeout shall win: normal transition, no timeout_o.
REQ-035 Without the macro, no counter shall exist, timeout_o shall be tied to 0, and REQ/REL shall wait indefinitely.

Verification
REQ-036 Reset, then data_i=32'hA5A5_0001 with valid_i=1 for one cycle -> next cycle xfer_req_o=1, xfer_data_o=32'hA5A5_0001, ready_o=0.
REQ-037 Responder raises ack 3 cycles after req and drops it 3 cycles after req falls (SYNC_DEPTH=2) -> single done_o pulse, back to IDLE, ready_o=1.
REQ-038 valid_i held high with changing data throughout the transfer -> xfer_data_o unchanged, only the first word is accepted.
REQ-039 xfer_ack_i held 1 after reset -> ready_o stays 0, and a valid_i=1 word is not accepted until ack falls.
REQ-040 rst_i=1 in REQ -> next cycle xfer_req_o=0, xfer_data_o=0, busy_o=0, no done_o.
REQ-041 Macro defined, TIMEOUT_CYCLES=8, ack never rises -> timeout_o after 8 cycles in REQ, REL, ack_s=0, IDLE with done_o=1; macro undefined -> controller remains in REQ.
